// File: rtl/sum_pkg.sv
// sum_pkg: shared types and constants for the sum_N operand loader.
//   load_state_t : loader FSM states (LOAD_A -> LOAD_B -> PRESENT)
//   DIG_W        : width of one hex digit on the input stream
package sum_pkg;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } load_state_t;

    localparam int DIG_W = 4;

endpackage

// File: rtl/dig_shreg.sv
// dig_shreg: M-bit hex-digit shift register with a digit counter.
// Digits enter at the LSB end, so the first digit ends up most significant.
// Optional feature macro: SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
//   (when defined, digits beyond M/4 are dropped and flagged on ovf).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of value and counter (wins over shift)
//   shift    : accept din this cycle
//   last     : din is the final digit; counter returns to 0
//   din      : hex digit
//   value    : assembled operand
//   ovf      : (macro only) a digit arrived with the register already full
module dig_shreg
    import sum_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             last,
    input  logic [DIG_W-1:0] din,
`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
    output logic             ovf,
`endif
    output logic [M-1:0]     value
);

    localparam int unsigned ND = M / DIG_W;
    localparam int unsigned CW = $clog2(ND + 1);
    localparam logic [CW-1:0] ND_C = CW'(ND);

    logic [M-1:0]  value_q, value_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;

    // Counter saturates at ND so it never wraps on over-long entries.
    assign full = (count_q == ND_C);

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (shift) begin
`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
            if (!full) begin
                value_d = (value_q << DIG_W) | M'(din);
                count_d = count_q + CW'(1);
            end
`else
            // Modulo-2^M entry: oldest digit falls off the top.
            value_d = (value_q << DIG_W) | M'(din);
            if (!full) begin
                count_d = count_q + CW'(1);
            end
`endif
            if (last) begin
                count_d = '0;
            end
        end
    end

`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
    assign ovf = shift & ~clr & full;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/sum_operand_loader.sv
// sum_operand_loader: serial hex-digit front end for the sum_N adder.
// Collects operand A, then operand B, one digit per valid/ready transfer
// (most-significant digit first, in_last closes each operand), then holds
// both operands on out_a/out_b with out_valid until out_ready.
// Optional feature macro: SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
//   defined  : digits beyond M/4 are dropped and set sticky err
//   undefined: modulo-2^M entry, err tied to 0
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   clr                          : synchronous clear, drops partial entry
//   in_valid/in_data/in_last     : digit stream input
//   in_ready                     : digit accepted this cycle (state decode)
//   out_a, out_b                 : operands to adder a/b
//   out_valid, out_ready         : operand handshake
//   err                          : sticky digit-overflow flag
module sum_operand_loader
    import sum_pkg::*;
#(
    parameter int unsigned M = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [DIG_W-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic [M-1:0]     out_a,
    output logic [M-1:0]     out_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    load_state_t state_q, state_d;
    logic        out_valid_q;
    logic        xfer;
    logic        hs;
    logic        clr_regs;
    logic        shift_a, shift_b;

    assign in_ready = (state_q != PRESENT);
    assign xfer     = in_valid & in_ready;
    assign hs       = out_valid_q & out_ready;
    // Completed handshake empties the operand registers for the next entry.
    assign clr_regs = clr | hs;
    assign shift_a  = xfer & (state_q == LOAD_A);
    assign shift_b  = xfer & (state_q == LOAD_B);

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = LOAD_A;
        end else begin
            unique case (state_q)
                LOAD_A:  if (xfer && in_last) state_d = LOAD_B;
                LOAD_B:  if (xfer && in_last) state_d = PRESENT;
                PRESENT: if (hs) state_d = LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_A;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= (state_d == PRESENT);
        end
    end

    assign out_valid = out_valid_q;

`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
    logic ovf_a, ovf_b;
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (clr_regs) begin
            err_d = 1'b0;
        end else if (ovf_a || ovf_b) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    dig_shreg #(
        .M(M)
    ) u_shreg_a (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_regs),
        .shift(shift_a),
        .last (in_last),
        .din  (in_data),
`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
        .ovf  (ovf_a),
`endif
        .value(out_a)
    );

    dig_shreg #(
        .M(M)
    ) u_shreg_b (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_regs),
        .shift(shift_b),
        .last (in_last),
        .din  (in_data),
`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
        .ovf  (ovf_b),
`endif
        .value(out_b)
    );

endmodule

// File: tb/tb_sum_operand_loader.sv
// Directed bench for sum_operand_loader with M = 8.
module tb_sum_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic       out_valid;
    logic       out_ready;
    logic       err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sum_operand_loader #(
        .M(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_a    (out_a),
        .out_b    (out_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the transfer edge.
    task automatic send(input logic [3:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_a", 32'(out_a), 32'h00);
        check("rst_out_b", 32'(out_b), 32'h00);
        check("rst_err", 32'(err), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic entry: A = 37, B = 12
        send(4'h3, 1'b0);
        send(4'h7, 1'b1);
        check("a_done_in_ready", 32'(in_ready), 32'h1);
        check("a_done_out_valid", 32'(out_valid), 32'h0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b1);
        check("basic_out_valid", 32'(out_valid), 32'h1);
        check("basic_out_a", 32'(out_a), 32'h37);
        check("basic_out_b", 32'(out_b), 32'h12);
        check("basic_sum", 32'({1'b0, out_a} + {1'b0, out_b}), 32'h049);
        check("basic_in_ready", 32'(in_ready), 32'h0);

        // Stall in PRESENT with random digit traffic
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 4'($urandom_range(0, 15));
            in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("stall_out_a", 32'(out_a), 32'h37);
            check("stall_out_b", 32'(out_b), 32'h12);
            check("stall_in_ready", 32'(in_ready), 32'h0);
            check("stall_out_valid", 32'(out_valid), 32'h1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        handshake();
        check("hs_out_valid", 32'(out_valid), 32'h0);
        check("hs_out_a", 32'(out_a), 32'h00);
        check("hs_out_b", 32'(out_b), 32'h00);
        check("hs_in_ready", 32'(in_ready), 32'h1);

        // Over-long A entry: 1, 2, 3(last); B = F(last)
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b1);
        send(4'hF, 1'b1);
        check("ovl_out_valid", 32'(out_valid), 32'h1);
`ifdef SUM_OPERAND_LOADER_DIGIT_LIMIT_EN
        check("ovl_out_a", 32'(out_a), 32'h12);
        check("ovl_err", 32'(err), 32'h1);
`else
        check("ovl_out_a", 32'(out_a), 32'h23);
        check("ovl_err", 32'(err), 32'h0);
`endif
        check("ovl_out_b", 32'(out_b), 32'h0F);
        handshake();
        check("ovl_hs_err", 32'(err), 32'h0);
        check("ovl_hs_out_a", 32'(out_a), 32'h00);

        // clr during a B digit transfer
        send(4'h5, 1'b0);
        send(4'hF, 1'b1);
        send(4'h4, 1'b0);
        check("pre_clr_out_a", 32'(out_a), 32'h5F);
        check("pre_clr_out_b", 32'(out_b), 32'h04);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h9;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        check("clr_out_a", 32'(out_a), 32'h00);
        check("clr_out_b", 32'(out_b), 32'h00);
        check("clr_in_ready", 32'(in_ready), 32'h1);
        check("clr_out_valid", 32'(out_valid), 32'h0);

        // One-digit operands confirm state is back at LOAD_A
        send(4'h6, 1'b1);
        check("one_a_out_valid", 32'(out_valid), 32'h0);
        send(4'h8, 1'b1);
        check("one_out_valid", 32'(out_valid), 32'h1);
        check("one_out_a", 32'(out_a), 32'h06);
        check("one_out_b", 32'(out_b), 32'h08);

        // Asynchronous reset mid-cycle while presenting
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_out_a", 32'(out_a), 32'h00);
        check("arst_out_b", 32'(out_b), 32'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("arst_in_ready", 32'(in_ready), 32'h1);
        check("arst_err", 32'(err), 32'h0);

        // Entry works normally after reset: A = A, B = 5 -> sum F
        send(4'hA, 1'b1);
        send(4'h5, 1'b1);
        check("post_out_a", 32'(out_a), 32'h0A);
        check("post_out_b", 32'(out_b), 32'h05);
        check("post_out_valid", 32'(out_valid), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sum_operand_loader.md
# sum_operand_loader

Sequential front end for the `sum_N` M-bit adder. It takes hexadecimal digits one at a time over a valid/ready handshake and assembles them into operand A, then operand B. It then presents both operands together, held stable, on a valid/ready output that drives the adder's `a`/`b` inputs directly. A downstream result register captures `y`/`cout` while the output handshake completes.

## Interface
- `M`, default 4: operand width in bits, equal to the adder's width. Must be a multiple of 4 and at least 4. Number of digits `ND = M/4`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `clr` in 1: synchronous clear. Discards any partial entry.
- `in_valid` in 1: a digit is present on `in_data`.
- `in_data` in 4: hex digit, most-significant first.
- `in_last` in 1: qualifies `in_data`. The digit is the final digit of the current operand.
- `in_ready` out 1: loader accepts a digit this cycle.
- `out_a` out M: operand A, to adder `a`.
- `out_b` out M: operand B, to adder `b`.
- `out_valid` out 1: both operands complete and stable.
- `out_ready` in 1: consumer has captured the result.
- `err` out 1: sticky digit-overflow flag (see Configuration).

## Operation
- State machine `LOAD_A -> LOAD_B -> PRESENT -> LOAD_A`.
- Reset and `clr` values:
  - state `LOAD_A`; `out_a = out_b = 0`; digit counter `0`; `err = 0`; `out_valid = 0`.
  - `in_ready` is 1 after reset or `clr`.
- `in_ready` decodes combinationally from state: 1 in `LOAD_A` and `LOAD_B`, 0 in `PRESENT`.
- A digit transfers when `in_valid & in_ready` are both high.
- Transfer in `LOAD_A`:
  - `out_a <= {out_a[M-5:0], in_data}`; digit counter increments.
  - If `in_last`, go to `LOAD_B` and reset the counter.
- `LOAD_B` behaves identically on `out_b`. On `in_last`, go to `PRESENT`.
- A one-digit operand (`in_last` on the first digit) is legal.
- Fewer than `ND` digits zero-extend in the upper bits, because registers start at 0.
- `PRESENT`: `out_valid = 1`; `out_a`/`out_b` are frozen.
  - On `out_valid & out_ready`: go to `LOAD_A`, clear both operand registers, clear `err`.
- `clr` has priority over any transfer in the same cycle: the digit is dropped, and state and registers take their clear values.
- `rst` asserted at any point, including mid-`PRESENT`: all outputs take reset values immediately.
- `in_data`/`in_last` are ignored when `in_valid` is 0, and whenever `in_ready` is 0.

## Timing
- `out_valid` is registered. It rises on the cycle after the B `in_last` transfer.
- `out_a`/`out_b` are final on that same cycle. The adder output is combinationally valid in that cycle.
- Output handshake cycle: `out_valid & out_ready`. The next cycle has `out_valid = 0` and `in_ready = 1`.
- Minimum cycles per operation: 2 digit cycles (1-digit operands) + 1 present/handshake cycle = 3 cycles.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- Macro: `SUM_OPERAND_LOADER_DIGIT_LIMIT_EN`.
- Defined: a digit transferred when the counter already equals `ND` is accepted but not shifted in.
  - `err` sets and holds until the output handshake, `clr`, or `rst`.
  - `in_last` on such a digit still advances state.
- Undefined: every digit shifts in and the oldest digit is lost (modulo-2^M entry). `err` is tied to 0.

## Structure
- Package `sum_pkg` holds:
  - `typedef enum logic [1:0] {LOAD_A, LOAD_B, PRESENT} load_state_t`.
  - `localparam int DIG_W = 4`.
- One sub-module, `dig_shreg`: an M-bit digit shift register with load-enable, clear and digit counter. It is instantiated twice, once for A and once for B.
- The FSM and handshake logic live in the top.
- `sum_N` is not instantiated inside; the integration level wires it up.

## Test plan
- Reset with `M = 8` → `in_ready = 1`, `out_valid = 0`, `out_a = out_b = 8'h00`, `err = 0`.
- A = digits 3, 7(last); B = 1, 2(last) → one cycle after the last transfer, `out_a = 8'h37`, `out_b = 8'h12`, `out_valid = 1`. Downstream `sum_N` gives `y = 8'h49`, `cout = 0`.
- Same entry, `out_ready` held 0 for 5 cycles, random `in_valid` → operands stable, `in_ready = 0`, no state change. `out_ready = 1` → next cycle `out_valid = 0`, operands 0.
- A = digits 1, 2, 3(last), B = F(last):
  - Macro defined: `out_a = 8'h12`, `err = 1`.
  - Macro undefined: `out_a = 8'h23`, `err = 0`.
  - Both builds: `out_b = 8'h0F`.
- A = 5, F(last), B digit 4, then `clr` together with a B digit transfer → next cycle `LOAD_A`, `out_a = out_b = 0`, digit discarded.
- `rst` pulsed mid-cycle while in `PRESENT` → `out_valid` drops asynchronously, operands 0, `in_ready = 1` after release.
